// File: rtl/scale_pkg.sv
// Shared types and defaults for the scaling arbiter slice.
package scale_pkg;

    // Channel encoding used in tags and arbitration vectors.
    localparam logic CH_POS = 1'b0;
    localparam logic CH_RPM = 1'b1;

    // Default latencies of the external multiply/divide cores.
    localparam int unsigned MUL_LAT_DEF   = 4;
    localparam int unsigned DIV_LAT_DEF   = 36;
    localparam int unsigned ISSUE_GAP_DEF = 1;

    // One entry of the in-flight tag delay line.
    typedef struct packed {
        logic valid;
        logic chan;
        logic div0;
    } tag_t;

    // Grant-to-done latency: operand reg, product reg, quotient reg plus the cores.
    function automatic int unsigned pipe_len(input int unsigned mul_lat,
                                             input int unsigned div_lat);
        return mul_lat + div_lat + 3;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is the pos channel, bit 1 the rpm channel.
module rr_arb2
    import scale_pkg::*;
(
    input  logic       CLK_60,
    input  logic       RST_B,
    input  logic       en,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // Grant decision: a lone eligible channel wins, a tie goes to the pointer.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (elig)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr_q == CH_RPM) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After any grant, priority passes to the channel that was not served.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = CH_RPM;
        end else if (gnt[1]) begin
            ptr_d = CH_POS;
        end
    end

    // Pointer register.
    always_ff @(posedge CLK_60) begin
        if (!RST_B) begin
            ptr_q <= CH_POS;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scale_arbiter.sv
// Shares one multiplier and one divider between the pos and rpm scaling requesters.
module scale_arbiter
    import scale_pkg::*;
#(
    parameter int unsigned MUL_LAT   = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT   = DIV_LAT_DEF,
    parameter int unsigned ISSUE_GAP = ISSUE_GAP_DEF
) (
    input  logic        CLK_60,
    input  logic        RST_B,
    input  logic        req_pos,
    input  logic [15:0] pos_a,
    input  logic [15:0] pos_b,
    input  logic [31:0] pos_div,
    output logic        ack_pos,
    output logic        done_pos,
    output logic [31:0] q_pos,
    output logic        div0_pos,
    input  logic        req_rpm,
    input  logic [15:0] rpm_a,
    input  logic [15:0] rpm_b,
    input  logic [31:0] rpm_div,
    output logic        ack_rpm,
    output logic        done_rpm,
    output logic [31:0] q_rpm,
    output logic        div0_rpm,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    output logic        busy
);

    localparam int unsigned PipeLen = pipe_len(MUL_LAT, DIV_LAT);
    // Tag stage that lines up with div_quotient for the matching operation.
    localparam int unsigned QuotTap = PipeLen - 2;

    tag_t        tag_q [PipeLen];
    logic [31:0] dsr_q [MUL_LAT + 1];
    logic [3:0]  gap_q, gap_d;
    logic [1:0]  inflight;
    logic [1:0]  elig;
    logic [1:0]  gnt;
    logic        grant;
    logic        gnt_chan;
    logic [15:0] sel_a, sel_b;
    logic [31:0] sel_div;
    logic        any_valid;
    tag_t        tap;

    // Per-channel in-flight flags and busy, derived from the tag line.
    always_comb begin
        inflight  = 2'b00;
        any_valid = 1'b0;
        for (int i = 0; i < int'(PipeLen); i++) begin
            if (tag_q[i].valid) begin
                any_valid              = 1'b1;
                inflight[tag_q[i].chan] = 1'b1;
            end
        end
    end

    assign busy = any_valid;
    assign elig = {req_rpm & ~inflight[CH_RPM], req_pos & ~inflight[CH_POS]};

    rr_arb2 u_arb (
        .CLK_60 (CLK_60),
        .RST_B  (RST_B),
        .en     (RST_B && (gap_q == 4'd0)),
        .elig   (elig),
        .gnt    (gnt)
    );

    assign ack_pos  = gnt[0];
    assign ack_rpm  = gnt[1];
    assign grant    = |gnt;
    assign gnt_chan = gnt[1];

    // Operand select for the granted channel.
    always_comb begin
        sel_a   = gnt_chan ? rpm_a   : pos_a;
        sel_b   = gnt_chan ? rpm_b   : pos_b;
        sel_div = gnt_chan ? rpm_div : pos_div;
    end

    // Gap counter next state: reload on grant, count down to zero otherwise.
    always_comb begin
        gap_d = gap_q;
        if (grant) begin
            gap_d = 4'(ISSUE_GAP - 1);
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    // Gap counter register.
    always_ff @(posedge CLK_60) begin
        if (!RST_B) begin
            gap_q <= 4'd0;
        end else begin
            gap_q <= gap_d;
        end
    end

    // Operand capture and divisor delay so the divisor meets its product.
    always_ff @(posedge CLK_60) begin
        if (!RST_B) begin
            mul_a        <= '0;
            mul_b        <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            for (int i = 0; i <= int'(MUL_LAT); i++) begin
                dsr_q[i] <= '0;
            end
        end else begin
            if (grant) begin
                mul_a    <= sel_a;
                mul_b    <= sel_b;
                dsr_q[0] <= sel_div;
            end
            for (int i = 1; i <= int'(MUL_LAT); i++) begin
                dsr_q[i] <= dsr_q[i-1];
            end
            div_dividend <= mul_p;
            div_divisor  <= dsr_q[MUL_LAT];
        end
    end

    // Tag delay line: one entry per cycle, valid only in grant cycles.
    always_ff @(posedge CLK_60) begin
        if (!RST_B) begin
            for (int i = 0; i < int'(PipeLen); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= grant ? tag_t'{valid: 1'b1, chan: gnt_chan, div0: (sel_div == '0)}
                              : tag_t'('0);
            for (int i = 1; i < int'(PipeLen); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tap = tag_q[QuotTap];

    // Result capture and done pulses; zero divisors report all-ones.
    always_ff @(posedge CLK_60) begin
        if (!RST_B) begin
            done_pos <= 1'b0;
            done_rpm <= 1'b0;
            q_pos    <= '0;
            q_rpm    <= '0;
            div0_pos <= 1'b0;
            div0_rpm <= 1'b0;
        end else begin
            done_pos <= tap.valid && (tap.chan == CH_POS);
            done_rpm <= tap.valid && (tap.chan == CH_RPM);
            if (tap.valid && (tap.chan == CH_POS)) begin
                q_pos    <= tap.div0 ? 32'hFFFF_FFFF : div_quotient;
                div0_pos <= tap.div0;
            end
            if (tap.valid && (tap.chan == CH_RPM)) begin
                q_rpm    <= tap.div0 ? 32'hFFFF_FFFF : div_quotient;
                div0_rpm <= tap.div0;
            end
        end
    end

endmodule

// File: tb/tb_scale_arbiter.sv
// Directed and random checks of scale_arbiter with behavioural multiply/divide cores.
module tb_scale_arbiter;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 36;
    localparam int LAT     = 43;
    localparam int NRAND   = 500;

    logic        CLK_60, RST_B;
    logic        req_pos, req_rpm;
    logic [15:0] pos_a, pos_b, rpm_a, rpm_b;
    logic [31:0] pos_div, rpm_div;
    logic        ack_pos, done_pos, div0_pos, ack_rpm, done_rpm, div0_rpm, busy;
    logic [31:0] q_pos, q_rpm;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_p, div_dividend, div_divisor, div_quotient;

    // Second instance with ISSUE_GAP=4; only its grant timing is observed.
    logic        r4_pos, r4_rpm, ack4_pos, ack4_rpm;
    logic        d4_dp, d4_dr, d4_zp, d4_zr, d4_busy;
    logic [31:0] d4_qp, d4_qr, d4_dd, d4_dv, zero32;
    logic [15:0] d4_ma, d4_mb;

    int n_pass  = 0;
    int n_total = 0;

    assign zero32 = 32'd0;

    scale_arbiter #(.MUL_LAT(4), .DIV_LAT(36), .ISSUE_GAP(1)) dut (
        .CLK_60(CLK_60), .RST_B(RST_B),
        .req_pos(req_pos), .pos_a(pos_a), .pos_b(pos_b), .pos_div(pos_div),
        .ack_pos(ack_pos), .done_pos(done_pos), .q_pos(q_pos), .div0_pos(div0_pos),
        .req_rpm(req_rpm), .rpm_a(rpm_a), .rpm_b(rpm_b), .rpm_div(rpm_div),
        .ack_rpm(ack_rpm), .done_rpm(done_rpm), .q_rpm(q_rpm), .div0_rpm(div0_rpm),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .busy(busy)
    );

    scale_arbiter #(.MUL_LAT(4), .DIV_LAT(36), .ISSUE_GAP(4)) dut4 (
        .CLK_60(CLK_60), .RST_B(RST_B),
        .req_pos(r4_pos), .pos_a(pos_a), .pos_b(pos_b), .pos_div(pos_div),
        .ack_pos(ack4_pos), .done_pos(d4_dp), .q_pos(d4_qp), .div0_pos(d4_zp),
        .req_rpm(r4_rpm), .rpm_a(rpm_a), .rpm_b(rpm_b), .rpm_div(rpm_div),
        .ack_rpm(ack4_rpm), .done_rpm(d4_dr), .q_rpm(d4_qr), .div0_rpm(d4_zr),
        .mul_a(d4_ma), .mul_b(d4_mb), .mul_p(zero32),
        .div_dividend(d4_dd), .div_divisor(d4_dv),
        .div_quotient(zero32), .busy(d4_busy)
    );

    initial CLK_60 = 1'b0;
    always #5 CLK_60 = ~CLK_60;

    // Behavioural cores: fixed-latency pipelines; divide by zero returns junk.
    logic [31:0] mpipe [MUL_LAT];
    logic [31:0] dpipe [DIV_LAT];
    always @(posedge CLK_60) begin
        mpipe[0] <= 32'(mul_a) * 32'(mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        dpipe[0] <= (div_divisor == 0) ? 32'hDEAD_BEEF : div_dividend / div_divisor;
        for (int i = 1; i < DIV_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mul_p        = mpipe[MUL_LAT-1];
    assign div_quotient = dpipe[DIV_LAT-1];

    function automatic logic [31:0] qmodel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [31:0] d);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return (d == 0) ? 32'hFFFF_FFFF : p / d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // cyc: drive point of the next cycle; tick: sample point of the next cycle.
    task automatic cyc();
        @(posedge CLK_60);
        #2;
    endtask

    task automatic tick();
        cyc();
        #2;
    endtask

    task automatic do_reset();
        cyc();
        RST_B = 1'b0;
        tick();
        RST_B = 1'b1;
    endtask

    // One isolated request; checks ack, busy window, done timing and result.
    task automatic run_single(input logic ch, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] d, input logic [31:0] eq,
                              input logic ediv0, input string tag);
        int bad_busy = 0;
        int bad_done = 0;
        cyc();
        if (ch) begin req_rpm = 1; rpm_a = a; rpm_b = b; rpm_div = d; end
        else    begin req_pos = 1; pos_a = a; pos_b = b; pos_div = d; end
        #2;
        chk({tag, "_ack"}, ch ? ack_rpm : ack_pos, 1);
        for (int k = 1; k <= LAT; k++) begin
            cyc();
            if (k == 1) begin req_pos = 0; req_rpm = 0; end
            #2;
            if (busy !== 1'b1) bad_busy++;
            if (k < LAT && (done_pos || done_rpm)) bad_done++;
        end
        chk({tag, "_busy_window"}, bad_busy, 0);
        chk({tag, "_no_early_done"}, bad_done, 0);
        chk({tag, "_done"}, ch ? done_rpm : done_pos, 1);
        chk({tag, "_q"}, ch ? q_rpm : q_pos, eq);
        chk({tag, "_div0"}, ch ? div0_rpm : div0_pos, ediv0);
        tick();
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_after"}, ch ? done_rpm : done_pos, 0);
    endtask

    // Both channels request together; pos must win, rpm follows one cycle later.
    task automatic run_both(input logic [15:0] pa, input logic [15:0] pb, input logic [31:0] pd,
                            input logic [31:0] eqp, input logic [15:0] ra,
                            input logic [15:0] rb, input logic [31:0] rd,
                            input logic [31:0] eqr, input string tag);
        cyc();
        req_pos = 1; pos_a = pa; pos_b = pb; pos_div = pd;
        req_rpm = 1; rpm_a = ra; rpm_b = rb; rpm_div = rd;
        #2;
        chk({tag, "_first_pos"}, ack_pos, 1);
        chk({tag, "_first_rpm_waits"}, ack_rpm, 0);
        cyc();
        req_pos = 0;
        #2;
        chk({tag, "_second_rpm"}, ack_rpm, 1);
        chk({tag, "_second_no_pos"}, ack_pos, 0);
        cyc();
        req_rpm = 0;
        #2;
        repeat (LAT - 3) tick();
        chk({tag, "_pos_not_early"}, done_pos, 0);
        tick();
        chk({tag, "_done_pos"}, done_pos, 1);
        chk({tag, "_rpm_after_pos"}, done_rpm, 0);
        chk({tag, "_q_pos"}, q_pos, eqp);
        tick();
        chk({tag, "_done_rpm"}, done_rpm, 1);
        chk({tag, "_q_rpm"}, q_rpm, eqr);
        chk({tag, "_div0_rpm"}, div0_rpm, 0);
        tick();
    endtask

    logic [31:0] rand_div;
    task automatic pick_div();
        rand_div = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
    endtask

    initial begin
        int bad, first_p, first_r, last, nacks;
        int np_iss, nr_iss, np_done, nr_done, wait_p, wait_r, viol;
        logic infl_p, infl_r, ackp_prev, ackr_prev, elig_p, elig_r;
        logic [31:0] exp_p, exp_r;
        logic        ez_p, ez_r;

        RST_B = 0; req_pos = 0; req_rpm = 0; r4_pos = 0; r4_rpm = 0;
        pos_a = 0; pos_b = 0; pos_div = 0; rpm_a = 0; rpm_b = 0; rpm_div = 0;
        repeat (3) @(posedge CLK_60);
        do_reset();

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_done", {done_pos, done_rpm}, 0);
        chk("rst_q_pos", q_pos, 0);
        chk("rst_q_rpm", q_rpm, 0);
        chk("rst_div0", {div0_pos, div0_rpm}, 0);
        chk("rst_mul_ops", {mul_a, mul_b}, 0);
        chk("rst_div_ops", div_dividend | div_divisor, 0);

        // ISSUE_GAP=4 spacing with both channels requesting continuously.
        cyc();
        r4_pos = 1; r4_rpm = 1;
        #2;
        bad = 0; first_p = -1; first_r = -1; last = -100; nacks = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) tick();
            if (ack4_pos && ack4_rpm) bad++;
            if (ack4_pos || ack4_rpm) begin
                if (c - last < 4) bad++;
                last = c;
                nacks++;
            end
            if (ack4_pos && first_p < 0) first_p = c;
            if (ack4_rpm && first_r < 0) first_r = c;
        end
        r4_pos = 0; r4_rpm = 0;
        chk("gap4_spacing", bad, 0);
        chk("gap4_first_pos", first_p, 0);
        chk("gap4_first_rpm", first_r, 4);
        chk("gap4_ack_count", nacks, 6);

        do_reset();
        run_single(1'b0, 16'd1000, 16'd20000, 32'd4096, 32'd4882, 1'b0, "pos_single");

        do_reset();
        run_both(16'd1000, 16'd20000, 32'd4096, 32'd4882,
                 16'd600, 16'd50000, 32'd3000, 32'd10000, "both");

        run_single(1'b1, 16'd5, 16'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, "rpm_div0");
        run_single(1'b1, 16'd5, 16'd7, 32'd7, 32'd5, 1'b0, "rpm_div7");

        // Held request: no re-grant until the cycle after done.
        cyc();
        req_pos = 1; pos_a = 100; pos_b = 200; pos_div = 3;
        #2;
        chk("hold_ack", ack_pos, 1);
        bad = 0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (ack_pos) bad++;
        end
        chk("hold_no_reack", bad, 0);
        chk("hold_done", done_pos, 1);
        chk("hold_q", q_pos, 6666);
        tick();
        chk("hold_reack_after_done", ack_pos, 1);

        // Reset at t+20 of that second operation discards it.
        cyc();
        req_pos = 0;
        #2;
        repeat (18) tick();
        cyc();
        RST_B = 0;
        #2;
        chk("midrst_busy_before", busy, 1);
        cyc();
        RST_B = 1;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_q_pos", q_pos, 0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (done_pos || done_rpm) bad++;
            tick();
        end
        chk("midrst_no_done", bad, 0);
        run_both(16'd3, 16'd1000, 32'd7, 32'd428, 16'd2, 16'd3, 32'd1, 32'd6, "after_rst");

        // Random back-to-back traffic on both channels.
        np_iss = 0; nr_iss = 0; np_done = 0; nr_done = 0;
        wait_p = 0; wait_r = 0; viol = 0;
        infl_p = 0; infl_r = 0; ackp_prev = 0; ackr_prev = 0;
        exp_p = 0; exp_r = 0; ez_p = 0; ez_r = 0;
        cyc();
        pos_a = 16'($urandom); pos_b = 16'($urandom); pick_div(); pos_div = rand_div;
        rpm_a = 16'($urandom); rpm_b = 16'($urandom); pick_div(); rpm_div = rand_div;
        req_pos = 1; req_rpm = 1;
        #2;
        for (int c = 0; c < 30000 && (np_done < NRAND || nr_done < NRAND); c++) begin
            if (c > 0) begin
                cyc();
                if (ackp_prev) begin
                    pos_a = 16'($urandom); pos_b = 16'($urandom); pick_div(); pos_div = rand_div;
                    if (np_iss == NRAND) req_pos = 0;
                end
                if (ackr_prev) begin
                    rpm_a = 16'($urandom); rpm_b = 16'($urandom); pick_div(); rpm_div = rand_div;
                    if (nr_iss == NRAND) req_rpm = 0;
                end
                #2;
            end
            elig_p = req_pos && !infl_p;
            elig_r = req_rpm && !infl_r;
            if (ack_pos && !elig_p) viol++;
            if (ack_rpm && !elig_r) viol++;
            if (ack_pos && ack_rpm) viol++;
            if (ack_rpm && elig_p) wait_p++;
            if (ack_pos) wait_p = 0;
            if (ack_pos && elig_r) wait_r++;
            if (ack_rpm) wait_r = 0;
            if (wait_p > 1 || wait_r > 1) viol++;
            if (done_pos) begin
                if (!infl_p) viol++;
                else begin
                    chk("rand_q_pos", q_pos, exp_p);
                    chk("rand_div0_pos", div0_pos, ez_p);
                    np_done++;
                end
                infl_p = 0;
            end
            if (done_rpm) begin
                if (!infl_r) viol++;
                else begin
                    chk("rand_q_rpm", q_rpm, exp_r);
                    chk("rand_div0_rpm", div0_rpm, ez_r);
                    nr_done++;
                end
                infl_r = 0;
            end
            if (ack_pos) begin
                exp_p = qmodel(pos_a, pos_b, pos_div); ez_p = (pos_div == 0);
                infl_p = 1; np_iss++;
            end
            if (ack_rpm) begin
                exp_r = qmodel(rpm_a, rpm_b, rpm_div); ez_r = (rpm_div == 0);
                infl_r = 1; nr_iss++;
            end
            ackp_prev = ack_pos;
            ackr_prev = ack_rpm;
        end
        req_pos = 0; req_rpm = 0;
        chk("rand_pos_completed", np_done, NRAND);
        chk("rand_rpm_completed", nr_done, NRAND);
        chk("rand_protocol_fairness", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scale_arbiter.md
Name: scale_arbiter

Overview:
Shares a single external multiplier core and divider core between two scaling requesters: position-to-DAC and rpm-to-DAC. Each request computes q = (a*b)/d. The block arbitrates between requests, issues operands into the multiply→divide pipeline, tags each operation, and returns the quotient to the correct requester. It sits between the encoder processing logic and the multiply/divide IP cores, which both run on CLK_60.

Parameters:
MUL_LAT, 4, multiplier core latency in cycles (mul_a/mul_b registered → mul_p valid)
DIV_LAT, 36, divider core latency in cycles (div_dividend/div_divisor → div_quotient valid)
ISSUE_GAP, 1, minimum cycles between successive grants (divider throughput); range 1..15

Ports:
CLK_60  in  1  system clock, 60 MHz
RST_B  in  1  synchronous reset, active-low
req_pos  in  1  position request; held high until ack_pos
pos_a  in  16  position multiplicand
pos_b  in  16  position multiplier
pos_div  in  32  position divisor
ack_pos  out  1  1-cycle grant pulse; operands sampled this cycle
done_pos  out  1  1-cycle pulse; q_pos and div0_pos valid
q_pos  out  32  position quotient, held until next done_pos
div0_pos  out  1  divisor was zero for the last position result
req_rpm, rpm_a, rpm_b, rpm_div, ack_rpm, done_rpm, q_rpm, div0_rpm  (same widths and meanings, rpm channel)
mul_a  out  16  to multiplier
mul_b  out  16  to multiplier
mul_p  in  32  from multiplier
div_dividend  out  32  to divider
div_divisor  out  32  to divider
div_quotient  in  32  from divider
busy  out  1  high while any operation is in flight

Behaviour:
- Reset (RST_B=0 at a CLK_60 edge): all outputs 0, in-flight pipeline flushed, round-robin pointer set to pos, gap counter cleared. Operations discarded by reset never produce done.
- Eligibility: a requester is eligible when its req is high and it has no operation in flight. Each channel has at most one outstanding operation.
- Grant: at most one grant per cycle, and only when the gap counter is 0. One eligible requester → it is granted. Both eligible → the round-robin pointer decides, and the pointer moves to the other channel after every grant. On a grant the gap counter loads ISSUE_GAP-1 and decrements to 0.
- Handshake: ack_x pulses in grant cycle t, and the a/b/div operands are captured at that edge. The requester drops req at or after t+1. If req is still high after done with the in-flight flag clear, that is treated as a new request.
- Pipeline:
  - mul_a/mul_b registered, valid from t+1.
  - mul_p sampled at t+1+MUL_LAT and registered into div_dividend. The captured divisor is delayed internally to align and drives div_divisor, valid from t+2+MUL_LAT.
  - div_quotient sampled at t+2+MUL_LAT+DIV_LAT into q_x.
  - done_x pulses in cycle t+3+MUL_LAT+DIV_LAT. Total ack→done latency L = MUL_LAT+DIV_LAT+3, which is 43 with defaults.
- Tag pipe: a shift register of {valid, chan, div0}, length L, with div0 = (div==0) evaluated at grant. Idle cycles hold mul_a/mul_b/div_* at their last value; do not care.
- Divide by zero: q_x forced to 32'hFFFF_FFFF and div0_x=1, whatever div_quotient is. Otherwise div0_x=0.
- busy = OR of tag-pipe valid bits.
- Arithmetic: product is unsigned 16x16→32. Quotient is unsigned, truncated. No saturation other than the div0 case.

Decomposition:
- Package scale_pkg:
  - CH_POS=1'b0, CH_RPM=1'b1
  - tag struct {valid, chan, div0}
  - default latency constants
- One natural sub-module, rr_arb2: two-input round-robin arbiter with enable (gap counter) and eligibility masks.
- Tag delay line and operand registers live in the top.

Test Plan:
- Single pos request, a=1000, b=20000, div=4096 (behavioural mult/div models) → ack_pos at cycle t, done_pos at t+43, q_pos=4882, div0_pos=0, busy high from t+1 to t+43.
- req_pos and req_rpm raised in the same cycle after reset → pos granted first, rpm granted next cycle (ISSUE_GAP=1). With rpm a=600, b=50000, div=3000, done_rpm is exactly 1 cycle after done_pos and q_rpm=10000.
- rpm divisor=0, a=5, b=7 → done_rpm with q_rpm=32'hFFFF_FFFF, div0_rpm=1. A following rpm request with div=7 → q_rpm=5, div0_rpm=0.
- req_pos held high continuously → no second ack_pos before done_pos; next ack_pos on the cycle after done_pos. Repeat with ISSUE_GAP=4 and both channels requesting; successive acks are at least 4 cycles apart.
- RST_B low for 1 cycle at t+20 of an in-flight pos op → no done_pos, q_pos=0, busy=0 next cycle, pointer=pos. A new request completes normally.
- 1000 random back-to-back requests on both channels → every quotient matches the (a*b)/d model, each channel's requests are served in order, and neither channel waits more than one foreign grant when both are eligible.
